// File: rtl/chime_sequencer_if.sv
// ----------------------------------------------------------------------------
// chime_sequencer_if
// Bundles the timekeeping-side inputs and buzzer-side outputs of the chime
// sequencer.
//   en, mode        global enable / hour-chime style (0 single, 1 strike)
//   value           current hour, BCD {tens, ones} or binary
//   alarm_eq        per-channel "alarm time equals now" level flags
//   alarm_mask      per-channel alarm enables
//   chime, busy     registered beep output and sequence-active flag
//   alarm_hit       channels behind the current or last alarm sequence
// master = the clock core driving the inputs, slave = the sequencer.
// ----------------------------------------------------------------------------
interface chime_sequencer_if #(
  parameter int VAL_W = 8,
  parameter int N_ALM = 2
);
  logic             en;
  logic             mode;
  logic [VAL_W-1:0] value;
  logic [N_ALM-1:0] alarm_eq;
  logic [N_ALM-1:0] alarm_mask;
  logic             chime;
  logic             busy;
  logic [N_ALM-1:0] alarm_hit;

  modport master (
    output en, mode, value, alarm_eq, alarm_mask,
    input  chime, busy, alarm_hit
  );

  modport slave (
    input  en, mode, value, alarm_eq, alarm_mask,
    output chime, busy, alarm_hit
  );
endinterface

// File: rtl/chime_sequencer.sv
// ----------------------------------------------------------------------------
// chime_sequencer
// Hourly-chime and alarm annunciator. Watches the hour value and alarm
// equality flags; on an hour change or a new alarm match it plays a beep
// sequence on chime (PULSE_LEN high, GAP_LEN low per beep).
// Ports:
//   clk   1 Hz clock, rising edge
//   rst   asynchronous active-high reset
//   bus   chime_sequencer_if.slave (en, mode, value, alarm_eq, alarm_mask in;
//         chime, busy, alarm_hit out, all registered)
// ----------------------------------------------------------------------------
module chime_sequencer #(
  parameter int VAL_W       = 8,
  parameter int BCD         = 1,
  parameter int N_ALM       = 2,
  parameter int PULSE_LEN   = 4,
  parameter int GAP_LEN     = 1,
  parameter int ALARM_BEEPS = 3
) (
  input  logic             clk,
  input  logic             rst,
  chime_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [3:0] PULSE_C = 4'(PULSE_LEN);
  localparam logic [3:0] GAP_C   = 4'(GAP_LEN);
  localparam logic [3:0] ALARM_C = 4'(ALARM_BEEPS);

  // Strike count for an hour value: 12-hour convention, malformed input -> 12.
  function automatic logic [3:0] hour12(input logic [VAL_W-1:0] v);
    logic [7:0] v8;
    logic [6:0] h;
    logic       bad;
    logic [3:0] res;
    v8  = 8'(v);
    h   = 7'd0;
    bad = 1'b0;
    if (BCD != 0) begin
      if ((v8[7:4] > 4'd9) || (v8[3:0] > 4'd9)) begin
        bad = 1'b1;
      end else begin
        h = ({3'd0, v8[7:4]} * 7'd10) + {3'd0, v8[3:0]};
      end
    end else begin
      if (v > VAL_W'(23)) begin
        bad = 1'b1;
      end else begin
        h = 7'(v);
      end
    end
    if (bad || (h > 7'd23) || (h == 7'd0)) begin
      res = 4'd12;
    end else if (h > 7'd12) begin
      res = 4'(h - 7'd12);
    end else begin
      res = 4'(h);
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic             primed_q, primed_d;
  logic             pend_q, pend_d;
  logic [N_ALM-1:0] pend_hit_q, pend_hit_d;
  logic [VAL_W-1:0] prev_value_q, prev_value_d;
  logic [N_ALM-1:0] prev_alm_q, prev_alm_d;
  logic [3:0]       beat_q, beat_d;
  logic [3:0]       strike_q, strike_d;
  logic             chime_q, chime_d;
  logic             busy_q, busy_d;
  logic [N_ALM-1:0] alarm_hit_q, alarm_hit_d;

  logic [N_ALM-1:0] alm_cur_s;
  logic [N_ALM-1:0] alm_rise_s;
  logic             active_s;
  logic             alm_evt_s;
  logic             hour_evt_s;

  // Event detection: edges of masked alarm flags and hour changes.
  always_comb begin
    alm_cur_s  = bus.alarm_eq & bus.alarm_mask;
    alm_rise_s = alm_cur_s & ~prev_alm_q;
    active_s   = bus.en && primed_q;
    alm_evt_s  = active_s && (|alm_rise_s);
    hour_evt_s = active_s && (bus.value != prev_value_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      primed_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_hit_q   <= '0;
      prev_value_q <= '0;
      prev_alm_q   <= '0;
      beat_q       <= 4'd0;
      strike_q     <= 4'd0;
      chime_q      <= 1'b0;
      busy_q       <= 1'b0;
      alarm_hit_q  <= '0;
    end else begin
      state_q      <= state_d;
      primed_q     <= primed_d;
      pend_q       <= pend_d;
      pend_hit_q   <= pend_hit_d;
      prev_value_q <= prev_value_d;
      prev_alm_q   <= prev_alm_d;
      beat_q       <= beat_d;
      strike_q     <= strike_d;
      chime_q      <= chime_d;
      busy_q       <= busy_d;
      alarm_hit_q  <= alarm_hit_d;
    end
  end

  // Next-state logic: sequencing, pending alarm merge, enable abort.
  always_comb begin
    state_d      = state_q;
    primed_d     = primed_q;
    pend_d       = pend_q;
    pend_hit_d   = pend_hit_q;
    beat_d       = beat_q;
    strike_d     = strike_q;
    alarm_hit_d  = alarm_hit_q;
    prev_value_d = bus.value;
    prev_alm_d   = alm_cur_s;

    if (!bus.en) begin
      // Abort; alarm_hit is intentionally kept for the display.
      state_d    = S_IDLE;
      pend_d     = 1'b0;
      pend_hit_d = '0;
      beat_d     = 4'd0;
      strike_d   = 4'd0;
    end else begin
      primed_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (alm_evt_s) begin
            state_d     = S_ON;
            beat_d      = PULSE_C;
            strike_d    = ALARM_C;
            alarm_hit_d = alm_rise_s;
          end else if (hour_evt_s) begin
            state_d  = S_ON;
            beat_d   = PULSE_C;
            strike_d = bus.mode ? hour12(bus.value) : 4'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ON: begin
          if (alm_evt_s) begin
            pend_d     = 1'b1;
            pend_hit_d = pend_hit_q | alm_rise_s;
          end else begin
            pend_d     = pend_q;
          end
          if (beat_q == 4'd1) begin
            if (strike_q != 4'd1) begin
              state_d = S_GAP;
              beat_d  = GAP_C;
            end else if (pend_q || alm_evt_s) begin
              // Chain straight into the pending alarm without a low cycle.
              state_d     = S_ON;
              beat_d      = PULSE_C;
              strike_d    = ALARM_C;
              alarm_hit_d = pend_hit_q | alm_rise_s;
              pend_d      = 1'b0;
              pend_hit_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            beat_d = beat_q - 4'd1;
          end
        end
        S_GAP: begin
          if (alm_evt_s) begin
            pend_d     = 1'b1;
            pend_hit_d = pend_hit_q | alm_rise_s;
          end else begin
            pend_d     = pend_q;
          end
          if (beat_q == 4'd1) begin
            state_d  = S_ON;
            beat_d   = PULSE_C;
            strike_d = strike_q - 4'd1;
          end else begin
            beat_d = beat_q - 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so chime/busy are registered.
  always_comb begin
    chime_d = (state_d == S_ON);
    busy_d  = (state_d != S_IDLE);
  end

  assign bus.chime     = chime_q;
  assign bus.busy      = busy_q;
  assign bus.alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// ----------------------------------------------------------------------------
// tb_chime_sequencer
// Directed test of chime_sequencer with PULSE_LEN=4, GAP_LEN=1,
// ALARM_BEEPS=3, BCD hours. Inputs change on the falling edge, outputs are
// sampled on the falling edge and accumulated into high/busy/beep counters.
// ----------------------------------------------------------------------------
module tb_chime_sequencer;

  logic clk;
  logic rst;

  chime_sequencer_if #(.VAL_W(8), .N_ALM(2)) bus ();

  chime_sequencer #(
    .VAL_W(8), .BCD(1), .N_ALM(2),
    .PULSE_LEN(4), .GAP_LEN(1), .ALARM_BEEPS(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int hi_cnt, bz_cnt, beep_cnt, fall_cnt;
  logic last_chime, last_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_meas();
    hi_cnt     = 0;
    bz_cnt     = 0;
    beep_cnt   = 0;
    fall_cnt   = 0;
    last_chime = bus.chime;
    last_busy  = bus.busy;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.chime) hi_cnt++;
      if (bus.busy) bz_cnt++;
      if (bus.chime && !last_chime) beep_cnt++;
      if (!bus.busy && last_busy) fall_cnt++;
      last_chime = bus.chime;
      last_busy  = bus.busy;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b1;
    bus.mode       = 1'b0;
    bus.value      = 8'h07;
    bus.alarm_eq   = 2'b00;
    bus.alarm_mask = 2'b00;
    clear_meas();
    step(1);
    chk("rst_chime", 32'(bus.chime), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hit", 32'(bus.alarm_hit), 32'd0);
    rst = 1'b0;

    // Priming: steady value after reset never chimes.
    clear_meas();
    step(10);
    chk("prime_hi", 32'(hi_cnt), 32'd0);

    // Single beep, mode 0.
    bus.value = 8'h09;
    clear_meas();
    step(8);
    chk("m0_a_hi", 32'(hi_cnt), 32'd4);
    bus.value = 8'h10;
    clear_meas();
    step(1);
    chk("m0_first_chime", 32'(bus.chime), 32'd1);
    chk("m0_first_busy", 32'(bus.busy), 32'd1);
    step(7);
    chk("m0_hi", 32'(hi_cnt), 32'd4);
    chk("m0_busy", 32'(bz_cnt), 32'd4);
    chk("m0_beeps", 32'(beep_cnt), 32'd1);

    // Strike count: 15 -> 3 beeps, 00 -> 12, 1A (bad digit) -> 12.
    bus.mode  = 1'b1;
    bus.value = 8'h15;
    clear_meas();
    step(20);
    chk("s15_hi", 32'(hi_cnt), 32'd12);
    chk("s15_busy", 32'(bz_cnt), 32'd14);
    chk("s15_beeps", 32'(beep_cnt), 32'd3);
    bus.value = 8'h00;
    clear_meas();
    step(65);
    chk("s00_hi", 32'(hi_cnt), 32'd48);
    chk("s00_busy", 32'(bz_cnt), 32'd59);
    chk("s00_beeps", 32'(beep_cnt), 32'd12);
    bus.value = 8'h1A;
    clear_meas();
    step(65);
    chk("s1a_beeps", 32'(beep_cnt), 32'd12);
    chk("s1a_busy", 32'(bz_cnt), 32'd59);

    // Alarm on masked channel 1, held high: one sequence only.
    bus.alarm_mask = 2'b10;
    bus.alarm_eq   = 2'b11;
    clear_meas();
    step(30);
    chk("alm_beeps", 32'(beep_cnt), 32'd3);
    chk("alm_hi", 32'(hi_cnt), 32'd12);
    chk("alm_busy", 32'(bz_cnt), 32'd14);
    chk("alm_hit", 32'(bus.alarm_hit), 32'd2);

    // Alarm during a 2-strike sequence is chained; second hour change dropped.
    bus.alarm_eq   = 2'b00;
    bus.alarm_mask = 2'b01;
    step(2);
    bus.value = 8'h02;
    clear_meas();
    step(2);
    bus.alarm_eq = 2'b01;
    bus.value    = 8'h03;
    step(30);
    chk("pend_hi", 32'(hi_cnt), 32'd20);
    chk("pend_busy", 32'(bz_cnt), 32'd23);
    chk("pend_beeps", 32'(beep_cnt), 32'd4);
    chk("pend_falls", 32'(fall_cnt), 32'd1);
    chk("pend_hit", 32'(bus.alarm_hit), 32'd1);

    // Same-edge hour change and alarm: alarm wins.
    bus.alarm_mask = 2'b11;
    bus.alarm_eq   = 2'b00;
    step(2);
    bus.value    = 8'h05;
    bus.alarm_eq = 2'b10;
    clear_meas();
    step(30);
    chk("prio_beeps", 32'(beep_cnt), 32'd3);
    chk("prio_busy", 32'(bz_cnt), 32'd14);
    chk("prio_hit", 32'(bus.alarm_hit), 32'd2);

    // Drop en mid-beep.
    bus.mode  = 1'b0;
    bus.value = 8'h06;
    step(2);
    chk("en_pre_chime", 32'(bus.chime), 32'd1);
    bus.en = 1'b0;
    step(1);
    chk("en_chime", 32'(bus.chime), 32'd0);
    chk("en_busy", 32'(bus.busy), 32'd0);
    chk("en_hit_held", 32'(bus.alarm_hit), 32'd2);
    bus.en = 1'b1;
    clear_meas();
    step(6);
    chk("en_resume_hi", 32'(hi_cnt), 32'd0);

    // Asynchronous reset mid-beep.
    bus.value = 8'h07;
    step(2);
    chk("rst_pre_chime", 32'(bus.chime), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_chime", 32'(bus.chime), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_hit", 32'(bus.alarm_hit), 32'd0);
    step(1);
    rst = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
